// File: rtl/sram_arbiter_pkg.sv
// sram_arbiter_pkg -- shared constants and types for the SRAM arbiter.
//   SRC_INST / SRC_DATA : outstanding-FIFO source tags (which master owns a response)
//   SIZE_*              : sram-like transfer size encodings
//   arb_state_e         : grant-lock state machine encoding
//   cnt_w()             : width of a counter that must hold 0..max_val
package sram_arbiter_pkg;

   localparam logic SRC_INST = 1'b0;
   localparam logic SRC_DATA = 1'b1;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   typedef enum logic {
      ST_ARB  = 1'b0,   // free to arbitrate this cycle
      ST_LOCK = 1'b1    // a request is on the bus waiting for m_addr_ok
   } arb_state_e;

   function automatic int cnt_w(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if -- bundles the two sram-like master ports and the shared
// slave port of the arbiter.
//   inst_* : instruction master (req/wr/size/addr/wdata in, addr_ok/data_ok/rdata out)
//   data_* : data master, same shape as inst_*
//   m_*    : shared slave (req/wr/size/addr/wdata out, addr_ok/data_ok/rdata in)
// Modports:
//   slave  : the arbiter itself; it is the slave of the two masters
//   master : the environment driving the masters and modelling the SRAM
interface sram_arbiter_if;

   logic        inst_req, inst_wr;
   logic [1:0]  inst_size;
   logic [31:0] inst_addr, inst_wdata;
   logic        inst_addr_ok, inst_data_ok;
   logic [31:0] inst_rdata;

   logic        data_req, data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr, data_wdata;
   logic        data_addr_ok, data_data_ok;
   logic [31:0] data_rdata;

   logic        m_req, m_wr;
   logic [1:0]  m_size;
   logic [31:0] m_addr, m_wdata;
   logic        m_addr_ok, m_data_ok;
   logic [31:0] m_rdata;

   modport slave (
      input  inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
      output inst_addr_ok, inst_data_ok, inst_rdata,
      input  data_req, data_wr, data_size, data_addr, data_wdata,
      output data_addr_ok, data_data_ok, data_rdata,
      output m_req, m_wr, m_size, m_addr, m_wdata,
      input  m_addr_ok, m_data_ok, m_rdata
   );

   modport master (
      output inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
      input  inst_addr_ok, inst_data_ok, inst_rdata,
      output data_req, data_wr, data_size, data_addr, data_wdata,
      input  data_addr_ok, data_data_ok, data_rdata,
      input  m_req, m_wr, m_size, m_addr, m_wdata,
      output m_addr_ok, m_data_ok, m_rdata
   );

endinterface

// File: rtl/sram_arbiter_src_fifo.sv
// arb_src_fifo -- 1-bit wide in-order FIFO remembering which master owns each
// accepted-but-not-completed transaction.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_push, i_din  : push a source tag (ignored when full unless popping too)
//   i_pop          : pop the head (ignored when empty)
//   o_dout         : current head tag
//   o_full/o_empty : status, distinguished by the extra pointer MSB
module arb_src_fifo #(
   parameter int DEPTH = 4
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_push,
   input  logic i_din,
   input  logic i_pop,
   output logic o_dout,
   output logic o_full,
   output logic o_empty
);

   localparam int AW = (DEPTH < 2) ? 1 : $clog2(DEPTH);

   logic [DEPTH-1:0] r_mem;
   logic [AW:0]      r_wptr, r_rptr;
   logic             w_do_push, w_do_pop;

   assign o_empty = (r_wptr == r_rptr);
   assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign o_dout  = r_mem[r_rptr[AW-1:0]];

   // When full, a simultaneous pop frees the head slot, which is exactly the
   // slot the write pointer addresses, so the push may proceed.
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wptr[AW-1:0]] <= i_din;
            r_wptr                <= r_wptr + 1'b1;
         end
         if (w_do_pop) r_rptr <= r_rptr + 1'b1;
      end
   end

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter -- two sram-like masters (inst, data) sharing one sram-like slave.
//   clk, reset : clock, synchronous active-high reset
//   bus        : sram_arbiter_if.slave (both master ports and the shared slave port)
//   err_unexp  : sticky, m_data_ok seen with nothing outstanding
//   perf_*     : grant / full-stall counters, present only with ARB_PERF_CNT_EN
// Data wins ties unless inst has lost STARVE_LIMIT handshakes in a row. A request
// left on m_req without m_addr_ok locks the grant until it is accepted. Responses
// return in order and are steered by an OUTS_DEPTH-deep source-tag FIFO.
module sram_arbiter
   import sram_arbiter_pkg::*;
#(
   parameter int OUTS_DEPTH   = 4,
   parameter int STARVE_LIMIT = 3
) (
   input  logic          clk,
   input  logic          reset,
   sram_arbiter_if.slave bus,
`ifdef ARB_PERF_CNT_EN
   output logic [31:0]   perf_inst_grants,
   output logic [31:0]   perf_data_grants,
   output logic [31:0]   perf_full_stalls,
`endif
   output logic          err_unexp
);

   localparam int             LW       = cnt_w(STARVE_LIMIT);
   localparam logic [LW-1:0]  LOSS_MAX = LW'(STARVE_LIMIT);

   arb_state_e    r_state, w_state_nxt;
   logic          r_lock_src, w_lock_src_nxt;
   logic [LW-1:0] r_loss;
   logic          r_err;

   logic w_gnt, w_gnt_req, w_m_req, w_hs;
   logic w_pop_ok, w_can_push;
   logic w_fifo_head, w_fifo_full, w_fifo_empty;

   // ---------------- arbitration ----------------
   always_comb begin
      w_gnt = SRC_DATA;
      if (r_state == ST_LOCK)
         w_gnt = r_lock_src;
      else if (bus.inst_req && (!bus.data_req || (r_loss == LOSS_MAX)))
         w_gnt = SRC_INST;
   end

   assign w_gnt_req  = (w_gnt == SRC_INST) ? bus.inst_req : bus.data_req;
   assign w_pop_ok   = bus.m_data_ok && !w_fifo_empty;
   assign w_can_push = !w_fifo_full || w_pop_ok;
   assign w_m_req    = !reset && w_gnt_req && w_can_push;
   assign w_hs       = w_m_req && bus.m_addr_ok;

   // ---------------- slave request side ----------------
   assign bus.m_req   = w_m_req;
   assign bus.m_wr    = (w_gnt == SRC_INST) ? bus.inst_wr    : bus.data_wr;
   assign bus.m_size  = (w_gnt == SRC_INST) ? bus.inst_size  : bus.data_size;
   assign bus.m_addr  = (w_gnt == SRC_INST) ? bus.inst_addr  : bus.data_addr;
   assign bus.m_wdata = (w_gnt == SRC_INST) ? bus.inst_wdata : bus.data_wdata;

   assign bus.inst_addr_ok = w_hs && (w_gnt == SRC_INST);
   assign bus.data_addr_ok = w_hs && (w_gnt == SRC_DATA);

   // ---------------- response side ----------------
   assign bus.inst_data_ok = !reset && w_pop_ok && (w_fifo_head == SRC_INST);
   assign bus.data_data_ok = !reset && w_pop_ok && (w_fifo_head == SRC_DATA);
   assign bus.inst_rdata   = bus.m_rdata;
   assign bus.data_rdata   = bus.m_rdata;

   arb_src_fifo #(.DEPTH(OUTS_DEPTH)) u_src_fifo (
      .i_clk   (clk),
      .i_reset (reset),
      .i_push  (w_hs),
      .i_din   (w_gnt),
      .i_pop   (bus.m_data_ok),
      .o_dout  (w_fifo_head),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty)
   );

   // ---------------- grant lock FSM ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_ARB;
         r_lock_src <= SRC_INST;
      end else begin
         r_state    <= w_state_nxt;
         r_lock_src <= w_lock_src_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_lock_src_nxt = r_lock_src;
      case (r_state)
         ST_ARB: begin
            if (w_m_req && !bus.m_addr_ok) begin
               w_state_nxt    = ST_LOCK;
               w_lock_src_nxt = w_gnt;
            end
         end
         ST_LOCK: begin
            if (w_hs) w_state_nxt = ST_ARB;
         end
         default: w_state_nxt = ST_ARB;
      endcase
   end

   // ---------------- inst starvation counter ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_loss <= '0;
      end else if (w_hs) begin
         if (w_gnt == SRC_INST)
            r_loss <= '0;
         else if (bus.inst_req && (r_loss != LOSS_MAX))
            r_loss <= r_loss + 1'b1;
      end
   end

   // ---------------- unexpected response flag ----------------
   always_ff @(posedge clk) begin
      if (reset)
         r_err <= 1'b0;
      else if (bus.m_data_ok && w_fifo_empty)
         r_err <= 1'b1;
   end

   assign err_unexp = r_err;

`ifdef ARB_PERF_CNT_EN
   logic [31:0] r_perf_inst, r_perf_data, r_perf_stall;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_perf_inst  <= '0;
         r_perf_data  <= '0;
         r_perf_stall <= '0;
      end else begin
         if (w_hs && (w_gnt == SRC_INST)) r_perf_inst  <= r_perf_inst + 32'd1;
         if (w_hs && (w_gnt == SRC_DATA)) r_perf_data  <= r_perf_data + 32'd1;
         // a pending request held off only because the FIFO is full
         if (w_gnt_req && !w_can_push)    r_perf_stall <= r_perf_stall + 32'd1;
      end
   end

   assign perf_inst_grants = r_perf_inst;
   assign perf_data_grants = r_perf_data;
   assign perf_full_stalls = r_perf_stall;
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter -- scoreboard bench for sram_arbiter (OUTS_DEPTH=4, STARVE_LIMIT=3).
// Stimulus pushes the expected address handshakes and responses into queues;
// a negedge monitor pops and compares whenever the DUT shows a handshake or a
// forwarded data_ok. Cycle-specific conditions (lock hold, full stall, reset,
// err_unexp) are checked inline by the stimulus.
module tb_sram_arbiter;
   import sram_arbiter_pkg::*;

   logic clk, reset, err_unexp;
`ifdef ARB_PERF_CNT_EN
   logic [31:0] perf_inst_grants, perf_data_grants, perf_full_stalls;
`endif

   sram_arbiter_if bus ();

   sram_arbiter #(.OUTS_DEPTH(4), .STARVE_LIMIT(3)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
`ifdef ARB_PERF_CNT_EN
      .perf_inst_grants (perf_inst_grants),
      .perf_data_grants (perf_data_grants),
      .perf_full_stalls (perf_full_stalls),
`endif
      .err_unexp (err_unexp)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct packed {
      logic [1:0]  ok;      // {inst_addr_ok, data_addr_ok}
      logic        wr;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
   } gnt_t;

   typedef struct packed {
      logic [1:0]  ok;      // {inst_data_ok, data_data_ok}
      logic [31:0] rdata;
   } rsp_t;

   gnt_t exp_g[$];
   rsp_t exp_r[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic set_inst(input logic req, input logic [31:0] a);
      bus.inst_req = req; bus.inst_addr = a;
   endtask

   task automatic set_data(input logic req, input logic [31:0] a);
      bus.data_req = req; bus.data_addr = a; bus.data_wdata = a ^ 32'h5A5A_0000;
   endtask

   task automatic set_slv(input logic aok, input logic dok, input logic [31:0] rd);
      bus.m_addr_ok = aok; bus.m_data_ok = dok; bus.m_rdata = rd;
   endtask

   task automatic idle();
      set_inst(1'b0, 32'h0); set_data(1'b0, 32'h0); set_slv(1'b0, 1'b0, 32'h0);
   endtask

   // inst master always reads a word; data master always writes a halfword
   task automatic push_gi(input logic [31:0] a);
      exp_g.push_back({2'b10, 1'b0, SIZE_WORD, a, 32'h0});
   endtask

   task automatic push_gd(input logic [31:0] a);
      exp_g.push_back({2'b01, 1'b1, SIZE_HALF, a, a ^ 32'h5A5A_0000});
   endtask

   task automatic push_r(input logic src, input logic [31:0] rd);
      exp_r.push_back({(src ? 2'b01 : 2'b10), rd});
   endtask

   task automatic next_cyc();
      @(posedge clk); #1;
   endtask

   task automatic tick();
      @(negedge clk); next_cyc();
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      gnt_t g;
      rsp_t r;
      if (bus.m_req && bus.m_addr_ok) begin
         if (exp_g.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL hs_unexpected: addr %0h with no handshake expected", bus.m_addr);
         end else begin
            g = exp_g.pop_front();
            chk("handshake", {bus.inst_addr_ok, bus.data_addr_ok, bus.m_wr, bus.m_size,
                              bus.m_addr, bus.m_wdata}, g);
         end
      end
      if (bus.inst_data_ok || bus.data_data_ok) begin
         if (exp_r.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL rsp_unexpected: ok %b%b rdata %0h with no response expected",
                     bus.inst_data_ok, bus.data_data_ok, bus.m_rdata);
         end else begin
            r = exp_r.pop_front();
            chk("response", {bus.inst_data_ok, bus.data_data_ok, bus.inst_rdata, bus.data_rdata},
                {r.ok, r.rdata, r.rdata});
         end
      end
   end

   // ---------------- directed sequence ----------------
   logic [0:7] gseq;   // 1 = data granted

   initial begin
      bus.inst_wr = 1'b0; bus.inst_size = SIZE_WORD; bus.inst_wdata = 32'h0;
      bus.data_wr = 1'b1; bus.data_size = SIZE_HALF;
      idle();
      gseq = 8'b1110_1110;

      // reset: requests and responses present but nothing may pass
      reset = 1'b1;
      set_inst(1'b1, 32'hBFC0_0000); set_slv(1'b1, 1'b1, 32'hDEAD);
      next_cyc();
      @(negedge clk);
      chk("rst_m_req",   bus.m_req, 0);
      chk("rst_addr_ok", {bus.inst_addr_ok, bus.data_addr_ok}, 0);
      chk("rst_data_ok", {bus.inst_data_ok, bus.data_data_ok}, 0);
      chk("rst_err",     err_unexp, 0);
      next_cyc();
      reset = 1'b0; idle();
      @(negedge clk);
      chk("post_rst_err",   err_unexp, 0);
      chk("post_rst_m_req", bus.m_req, 0);
      next_cyc();

      // both masters request continuously: D,D,D,I,D,D,D,I; one response per cycle
      for (int k = 0; k < 8; k++) begin
         set_inst(1'b1, 32'hBFC0_0000); set_data(1'b1, 32'h8000_0000);
         set_slv(1'b1, (k >= 1), 32'(32'h100 + k));
         if (gseq[k]) push_gd(32'h8000_0000); else push_gi(32'hBFC0_0000);
         if (k >= 1) push_r(gseq[k-1], 32'(32'h100 + k));
         tick();
      end
      idle(); set_slv(1'b1, 1'b1, 32'h108);
      push_r(gseq[7], 32'h108);
      @(negedge clk);
      chk("idle_m_req", bus.m_req, 0);
      next_cyc();
      idle(); tick();

      // lock: inst waits 3 cycles for m_addr_ok while data requests
      set_inst(1'b1, 32'hBFC0_0000);
      for (int k = 0; k < 3; k++) begin
         if (k >= 1) set_data(1'b1, 32'h8000_0040);
         @(negedge clk);
         chk("lock_m_req",   bus.m_req, 1);
         chk("lock_m_addr",  bus.m_addr, 32'hBFC0_0000);
         chk("lock_addr_ok", {bus.inst_addr_ok, bus.data_addr_ok}, 0);
         next_cyc();
      end
      set_slv(1'b1, 1'b0, 32'h0); push_gi(32'hBFC0_0000); tick();
      set_inst(1'b0, 32'h0); push_gd(32'h8000_0040); tick();
      idle(); set_slv(1'b0, 1'b1, 32'h55); push_r(SRC_INST, 32'h55); tick();
      set_slv(1'b0, 1'b1, 32'h66); push_r(SRC_DATA, 32'h66); tick();
      idle(); tick();

      // FIFO full: four outstanding, fifth stalls; pop+push in one cycle keeps it full
      for (int k = 0; k < 4; k++) begin
         set_data(1'b1, 32'(32'h8000_1000 + 4 * k)); set_slv(1'b1, 1'b0, 32'h0);
         push_gd(32'(32'h8000_1000 + 4 * k));
         tick();
      end
      set_inst(1'b1, 32'hBFC0_0200); set_data(1'b1, 32'h8000_1010);
      @(negedge clk);
      chk("full_m_req",   bus.m_req, 0);
      chk("full_addr_ok", {bus.inst_addr_ok, bus.data_addr_ok}, 0);
      next_cyc();
      set_inst(1'b0, 32'h0); set_slv(1'b1, 1'b1, 32'hA0);
      push_gd(32'h8000_1010); push_r(SRC_DATA, 32'hA0);
      tick();
      set_data(1'b1, 32'h8000_1014); set_slv(1'b1, 1'b0, 32'h0);
      @(negedge clk);
      chk("still_full_m_req", bus.m_req, 0);
      next_cyc();
      for (int k = 1; k <= 4; k++) begin
         idle(); set_slv(1'b0, 1'b1, 32'(32'hA0 + k)); push_r(SRC_DATA, 32'(32'hA0 + k));
         tick();
      end
      idle(); tick();

      // in-order routing: I,D,I then rdata 0x11,0x22,0x33
      set_inst(1'b1, 32'hBFC0_0100); set_slv(1'b1, 1'b0, 32'h0); push_gi(32'hBFC0_0100); tick();
      set_inst(1'b0, 32'h0); set_data(1'b1, 32'h8000_2000); push_gd(32'h8000_2000); tick();
      set_data(1'b0, 32'h0); set_inst(1'b1, 32'hBFC0_0104); push_gi(32'hBFC0_0104); tick();
      idle(); set_slv(1'b0, 1'b1, 32'h11); push_r(SRC_INST, 32'h11); tick();
      set_slv(1'b0, 1'b1, 32'h22); push_r(SRC_DATA, 32'h22); tick();
      set_slv(1'b0, 1'b1, 32'h33); push_r(SRC_INST, 32'h33); tick();
      idle();
      @(negedge clk);
      chk("no_err_yet", err_unexp, 0);
      next_cyc();

      // unexpected response with empty FIFO: sticky error, nothing forwarded
      set_slv(1'b0, 1'b1, 32'h77);
      @(negedge clk);
      chk("unexp_not_fwd", {bus.inst_data_ok, bus.data_data_ok}, 0);
      next_cyc();
      idle();
      @(negedge clk); chk("err_set",  err_unexp, 1); next_cyc();
      @(negedge clk); chk("err_held", err_unexp, 1); next_cyc();

      // two outstanding, then reset discards them
      set_inst(1'b1, 32'hBFC0_0300); set_slv(1'b1, 1'b0, 32'h0); push_gi(32'hBFC0_0300); tick();
      set_inst(1'b0, 32'h0); set_data(1'b1, 32'h8000_3000); push_gd(32'h8000_3000); tick();
      reset = 1'b1;
      set_data(1'b0, 32'h0); set_inst(1'b1, 32'hBFC0_0304); set_slv(1'b1, 1'b1, 32'h88);
      @(negedge clk);
      chk("rst2_m_req",   bus.m_req, 0);
      chk("rst2_data_ok", {bus.inst_data_ok, bus.data_data_ok}, 0);
      next_cyc();
      reset = 1'b0; idle(); set_slv(1'b0, 1'b1, 32'h99);
      @(negedge clk);
      chk("rst2_err_clr",  err_unexp, 0);
      chk("rst2_discard",  {bus.inst_data_ok, bus.data_data_ok}, 0);
      next_cyc();
      idle();
      @(negedge clk);
      chk("first_cyc_unexp", err_unexp, 1);
      next_cyc();

      chk("grants_left",    32'(exp_g.size()), 0);
      chk("responses_left", 32'(exp_r.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
